arb_rr: RTL
===========

# arb_rr

Parametrised bus arbiter for the shared main-memory bus, successor to the fixed-priority arbiter. It grants the bus to one of N internal requesters using two priority classes: fixed priority within the high class and round-robin within the low class. An optional starvation guard lets the low class win after a run of high-class grants. It also hands the whole bus to an external master through a request/grant handshake; grants change only at bus-cycle boundaries.

## Interface
- N, 8, number of internal requesters (2..16); channel 0 is the default (parked) owner
- IDW, 4, width of grant_id; must satisfy 2^IDW >= N
- STARVE_MAX, 7, number of consecutive high-class grants before the low class is forced (1..15)

- clk  in  1  system clock, all logic on rising edge
- resetl  in  1  synchronous reset, active-low
- req  in  N  per-channel request, level, held until granted cycle completes
- prio_hi  in  N  per-channel class select: 1 = high class, 0 = low class
- ack  in  1  current bus cycle completes this clock (arbitration point)
- idle  in  1  no bus cycle in flight (arbitration point)
- ext_br  in  1  external master bus request, level
- grant  out  N  one-hot internal grant; all-zero while external master owns bus
- grant_id  out  IDW  binary index of granted channel; 0 when external owns
- ext_bg  out  1  bus granted to external master
- arb_pt  out  1  combinational: arbitration point this clock (ack | idle)

## Operation
- Channel 0 is always treated as requesting, in the low class, and is the final fallback: the bus is never ungranted internally.
- Arbitration occurs only on clocks where arb_pt = 1; the result is registered on that edge. Otherwise grant, grant_id, and state hold.
- Winner selection, in order:
  1. Forced low: under ARB_STARVE_EN, if the starve counter = STARVE_MAX and any low-class channel other than 0 requests, pick the round-robin low winner.
  2. Any high-class req: pick the lowest index among them.
  3. ext_br = 1: enter XOWN.
  4. Round-robin low class, channels 1..N-1: search starts at last_lo+1 and wraps from N-1 to 1.
  5. Otherwise channel 0.
- last_lo register, IDW bits:
  - Updated only when a low-class channel other than 0 wins.
  - Reset value N-1, so the first search starts at channel 1.
- States:
  - INT: internal owner. The arbitration rule above applies.
  - XOWN: ext_bg = 1, grant = 0. Stays while ext_br = 1. On the first clock with ext_br = 0, returns to INT with grant = channel 0 (1<<0), then arbitrates normally on later arb_pt.
  - While in XOWN, ack and idle are ignored.
- prio_hi may change at any time; it is sampled only at arbitration points.
- A channel dropping req mid-cycle does not change grant before the next arb_pt.

## Timing
- Reset values:
  - grant = 1 (channel 0)
  - grant_id = 0
  - ext_bg = 0
  - state = INT
  - last_lo = N-1
  - starve counter = 0
- Reset takes precedence over arbitration on the same edge. A reset mid-XOWN drops ext_bg the next cycle.
- Latency: req asserted with arb_pt high in clock k produces grant in clock k+1. If arb_pt is low, the grant follows in the clock after the next arb_pt.
- ext_br rising to ext_bg rising: 1 clock after the first arb_pt at which no high-class req is pending.
- ext_br falling to ext_bg falling: 1 clock.
- ext_bg and any grant bit are never high together. grant is always one-hot in INT.
- Starve counter, 4 bits, saturating:
  - Increments when a high-class channel wins.
  - Clears when any low-class channel (including 0) wins or on entering XOWN.
  - Holds otherwise.

## Configuration
- ARB_STARVE_EN defined: starve counter and forced-low rule compiled in.
- ARB_STARVE_EN undefined: counter absent, strict class priority; STARVE_MAX unused.

## Test plan
- Reset, no req, idle = 1 -> grant = 0x01, grant_id = 0, ext_bg = 0 every cycle.
- N = 8, prio_hi = 0, req = 0x0E, ack pulsed every cycle -> grant sequence 0x02, 0x04, 0x08, 0x02…; last_lo wraps from 3 back to 1.
- req = 0x24, prio_hi = 0x20, idle = 1 -> grant = 0x20 next clock. Drop req[5] with ack = 0 -> grant still 0x20 until ack, then grant = 0x04.
- ARB_STARVE_EN, STARVE_MAX = 3, req = 0x82, prio_hi = 0x80, ack = 1 continuous -> 0x80 three times, then 0x02, then 0x80 resumes.
- Grant on ch 3, ext_br = 1, ack = 0 for 4 clocks then 1 -> ext_bg = 1 and grant = 0 the clock after ack. ext_br = 0 -> ext_bg = 0, grant = 0x01 next clock.
- In XOWN, assert resetl = 0 for one clock -> ext_bg = 0, grant = 0x01, counters cleared on the following clock.

Source files
------------

// File: rtl/arb_rr.sv
// rtl/arb_rr.sv - two-class bus arbiter (fixed-priority high, round-robin low) with external master handoff
// Optional starvation guard compiled in with ARB_STARVE_EN.
module arb_rr #(
  parameter int N          = 8,
  parameter int IDW        = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic           clk,
  input  logic           resetl,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   prio_hi,
  input  logic           ack,
  input  logic           idle,
  input  logic           ext_br,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           ext_bg,
  output logic           arb_pt
);

  if (N < 2 || N > 16 || (1 << IDW) < N || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
    $error("arb_rr: parameter out of range");
  end

  typedef enum logic {ST_INT, ST_XOWN} state_t;

  localparam logic [N-1:0] CH0_MASK = N'(1);

  state_t         state;
  logic [IDW-1:0] last_lo;
  logic [N-1:0]   hi_req, lo_req;
  logic           hi_any, lo_any, forced;
  logic [IDW-1:0] hi_idx, lo_idx;
  int             best_d, d;

  assign arb_pt = ack | idle;

  // Channel 0 is permanently low class and is the fallback, so it never enters either search.
  assign hi_req = req & prio_hi & ~CH0_MASK;
  assign lo_req = req & ~prio_hi & ~CH0_MASK;
  assign hi_any = |hi_req;
  assign lo_any = |lo_req;

  always_comb begin
    hi_idx = '0;
    for (int i = N - 1; i >= 1; i--) begin
      if (hi_req[i]) hi_idx = IDW'(i);
    end
  end

  // Pick the requester closest after last_lo on the ring 1..N-1.
  always_comb begin
    lo_idx = '0;
    best_d = N;
    d      = 0;
    for (int i = 1; i < N; i++) begin
      d = i - int'(last_lo) - 1;
      if (d < 0) d = d + (N - 1);
      if (lo_req[i] && d < best_d) begin
        best_d = d;
        lo_idx = IDW'(i);
      end
    end
  end

`ifdef ARB_STARVE_EN
  logic [3:0] starve_cnt;

  assign forced = (starve_cnt == 4'(STARVE_MAX)) && lo_any;

  always_ff @(posedge clk) begin
    if (!resetl) begin
      starve_cnt <= '0;
    end else if (state == ST_INT && arb_pt) begin
      if (!forced && hi_any) begin
        if (starve_cnt != 4'hf) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end
`else
  assign forced = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetl) begin
      state    <= ST_INT;
      grant    <= CH0_MASK;
      grant_id <= '0;
      ext_bg   <= 1'b0;
      last_lo  <= IDW'(N - 1);
    end else begin
      case (state)
        ST_INT: begin
          if (arb_pt) begin
            if (forced || (!hi_any && !ext_br && lo_any)) begin
              grant    <= CH0_MASK << lo_idx;
              grant_id <= lo_idx;
              last_lo  <= lo_idx;
            end else if (hi_any) begin
              grant    <= CH0_MASK << hi_idx;
              grant_id <= hi_idx;
            end else if (ext_br) begin
              state    <= ST_XOWN;
              grant    <= '0;
              grant_id <= '0;
              ext_bg   <= 1'b1;
            end else begin
              grant    <= CH0_MASK;
              grant_id <= '0;
            end
          end
        end
        ST_XOWN: begin
          if (!ext_br) begin
            state    <= ST_INT;
            grant    <= CH0_MASK;
            grant_id <= '0;
            ext_bg   <= 1'b0;
          end
        end
        default: state <= ST_INT;
      endcase
    end
  end

endmodule
